// File: rtl/hs_req_ack_ctrl.sv
// Source-side 4-phase req/ack controller: captures a word over valid/ready,
// sequences req_o against a synchronized ack_i, and aborts on a programmable timeout.
module hs_req_ack_ctrl #(
  parameter int DP   = 2,
  parameter int DW   = 32,
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   din_i,
  input  logic            din_valid_i,
  output logic            din_ready_o,
  output logic [DW-1:0]   data_o,
  output logic            req_o,
  input  logic            ack_i,
  input  logic [TO_W-1:0] timeout_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [DP-1:0]     ack_sync_r;
  logic              ack_s;
  logic [TO_W-1:0]   cnt_r, cnt_s;
  logic [DW-1:0]     data_r, data_s;
  logic              req_r, req_s;
  logic              done_r, done_s;
  logic              to_r, to_s;
  logic              din_ready_s;
  logic              to_hit_s;

  // ack_i synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_r <= {DP{1'b0}};
    end else begin
      ack_sync_r <= {ack_sync_r[DP-2:0], ack_i};
    end
  end

  assign ack_s       = ack_sync_r[DP-1];
  assign din_ready_s = (state_r == IDLE) && !ack_s;
  // Equality compare: lowering timeout_i below cnt mid-transfer disables the abort.
  assign to_hit_s    = (timeout_i != {TO_W{1'b0}}) && (cnt_r == (timeout_i - TO_W'(1'b1)));

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    req_s   = req_r;
    done_s  = 1'b0;
    to_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (din_valid_i && din_ready_s) begin
          data_s  = din_i;
          req_s   = 1'b1;
          cnt_s   = {TO_W{1'b0}};
          state_s = REQ_HI;
        end else begin
          req_s   = 1'b0;
        end
      end
      REQ_HI: begin
        cnt_s = cnt_r + TO_W'(1'b1);
        // ack takes priority over a simultaneous timeout
        if (ack_s) begin
          req_s   = 1'b0;
          done_s  = 1'b1;
          state_s = REQ_LO;
        end else if (to_hit_s) begin
          req_s   = 1'b0;
          to_s    = 1'b1;
          state_s = REQ_LO;
        end else begin
          req_s   = 1'b1;
        end
      end
      REQ_LO: begin
        req_s = 1'b0;
        if (!ack_s) begin
          state_s = IDLE;
        end else begin
          state_s = REQ_LO;
        end
      end
      default: begin
        req_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {TO_W{1'b0}};
      data_r  <= {DW{1'b0}};
      req_r   <= 1'b0;
      done_r  <= 1'b0;
      to_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      req_r   <= req_s;
      done_r  <= done_s;
      to_r    <= to_s;
    end
  end

  assign din_ready_o = din_ready_s;
  assign data_o      = data_r;
  assign req_o       = req_r;
  assign busy_o      = (state_r != IDLE);
  assign done_o      = done_r;
  assign timeout_o   = to_r;

endmodule

// File: tb/tb_hs_req_ack_ctrl.sv
// Self-checking bench for hs_req_ack_ctrl: directed timing checks plus a
// scoreboard of accepted words compared against data_o on each done_o pulse.
module tb_hs_req_ack_ctrl;

  localparam int DP   = 2;
  localparam int DW   = 32;
  localparam int TO_W = 16;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   din_i;
  logic            din_valid_i;
  logic            din_ready_o;
  logic [DW-1:0]   data_o;
  logic            req_o;
  logic            ack_i;
  logic [TO_W-1:0] timeout_i;
  logic            busy_o;
  logic            done_o;
  logic            timeout_o;

  logic            man_ack;
  logic            peer_en;
  logic            peer_ack;
  int              peer_cnt;

  int              checks;
  int              errors;
  int              done_cnt;
  int              to_cnt;
  logic [DW-1:0]   sb[$];

  hs_req_ack_ctrl #(.DP(DP), .DW(DW), .TO_W(TO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_i       (din_i),
    .din_valid_i (din_valid_i),
    .din_ready_o (din_ready_o),
    .data_o      (data_o),
    .req_o       (req_o),
    .ack_i       (ack_i),
    .timeout_i   (timeout_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o)
  );

  assign ack_i = peer_en ? peer_ack : man_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 100) begin
      tick(1);
      n++;
    end
    check_eq(tag, {63'd0, busy_o}, 64'd0);
  endtask

  task automatic wait_dones(input string tag, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      tick(1);
      n++;
    end
    check_eq(tag, 64'(done_cnt), 64'(target));
  endtask

  // Peer model: raises ack three cycles after seeing req, drops it after req falls
  always @(negedge clk) begin
    if (!peer_en) begin
      peer_ack <= 1'b0;
      peer_cnt <= 0;
    end else if (req_o && !peer_ack) begin
      if (peer_cnt == 2) begin
        peer_ack <= 1'b1;
        peer_cnt <= 0;
      end else begin
        peer_cnt <= peer_cnt + 1;
      end
    end else if (!req_o && peer_ack) begin
      peer_ack <= 1'b0;
    end
  end

  // Scoreboard consumer: each done_o pulse must match the oldest accepted word
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_done", 64'd1, 64'd0);
        end else begin
          check_eq("sb_data", {32'd0, data_o}, {32'd0, sb.pop_front()});
        end
      end
      if (timeout_o) to_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks = 0; errors = 0; done_cnt = 0; to_cnt = 0;
    rst = 1'b1; din_i = '0; din_valid_i = 1'b0; man_ack = 1'b0;
    peer_en = 1'b0; timeout_i = '0;
    tick(3);
    check_eq("rst_req", {63'd0, req_o}, 64'd0);
    check_eq("rst_data", {32'd0, data_o}, 64'd0);
    check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("rst_done_to", {62'd0, done_o, timeout_o}, 64'd0);
    rst = 1'b0;
    tick(1);
    check_eq("idle_ready", {63'd0, din_ready_o}, 64'd1);

    // Basic transfer
    din_i = 32'hA5A5_0001; din_valid_i = 1'b1; sb.push_back(32'hA5A5_0001);
    tick(1);                                     // E0
    din_valid_i = 1'b0;
    check_eq("basic_req_e0", {63'd0, req_o}, 64'd1);
    check_eq("basic_data_e0", {32'd0, data_o}, 64'hA5A5_0001);
    check_eq("basic_ready_e0", {62'd0, din_ready_o, busy_o}, 64'd1);
    tick(4);                                     // E4
    man_ack = 1'b1;
    tick(2);                                     // E6
    check_eq("basic_req_e6", {63'd0, req_o}, 64'd1);
    tick(1);                                     // E7
    check_eq("basic_req_e7", {63'd0, req_o}, 64'd0);
    check_eq("basic_done_e7", {63'd0, done_o}, 64'd1);
    tick(1);                                     // E8
    check_eq("basic_done_e8", {63'd0, done_o}, 64'd0);
    tick(1);                                     // E9
    man_ack = 1'b0;
    tick(2);                                     // E11
    check_eq("basic_ready_e11", {62'd0, din_ready_o, busy_o}, 64'd1);
    tick(1);                                     // E12
    check_eq("basic_ready_e12", {62'd0, din_ready_o, busy_o}, 64'd2);
    check_eq("basic_data_hold", {32'd0, data_o}, 64'hA5A5_0001);

    // Back-to-back with peer model
    peer_en = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      din_i = 32'(w); din_valid_i = 1'b1; sb.push_back(32'(w));
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!din_ready_o && n < 200);
      check_eq("b2b_ready_seen", {63'd0, din_ready_o}, 64'd1);
      tick(1);
    end
    din_valid_i = 1'b0;
    wait_dones("b2b_dones", 4);
    wait_idle("b2b_idle");
    peer_en = 1'b0;
    tick(2);

    // Timeout
    timeout_i = 16'd10;
    din_i = 32'h0000_0055; din_valid_i = 1'b1;
    tick(1);                                     // E0
    din_valid_i = 1'b0;
    n = 0;
    while (req_o && n < 50) begin
      n++;
      tick(1);
    end
    check_eq("to_req_cycles", 64'(n), 64'd10);
    check_eq("to_pulse", {62'd0, timeout_o, done_o}, 64'd2);
    tick(1);
    check_eq("to_pulse_end", {63'd0, timeout_o}, 64'd0);
    check_eq("to_idle", {63'd0, busy_o}, 64'd0);
    check_eq("to_count", 64'(to_cnt), 64'd1);
    check_eq("to_no_done", 64'(done_cnt), 64'd4);

    // Ack/timeout collision
    timeout_i = 16'd8;
    din_i = 32'h0000_0077; din_valid_i = 1'b1; sb.push_back(32'h0000_0077);
    tick(1);                                     // E0
    din_valid_i = 1'b0;
    tick(5);                                     // E5
    man_ack = 1'b1;
    tick(2);                                     // E7
    check_eq("col_req_e7", {63'd0, req_o}, 64'd1);
    tick(1);                                     // E8
    check_eq("col_done_to", {62'd0, done_o, timeout_o}, 64'd2);
    man_ack = 1'b0;
    wait_idle("col_idle");
    check_eq("col_to_count", 64'(to_cnt), 64'd1);

    // Stale ack through reset release
    timeout_i = 16'd0;
    man_ack = 1'b1; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check_eq("stale_ready", {63'd0, din_ready_o}, 64'd0);
    din_i = 32'h0000_0099; din_valid_i = 1'b1;
    tick(3);                                     // Ek
    check_eq("stale_no_accept", {62'd0, busy_o, req_o}, 64'd0);
    man_ack = 1'b0;
    tick(1);                                     // Ek+1
    check_eq("stale_ready_k1", {63'd0, din_ready_o}, 64'd0);
    sb.push_back(32'h0000_0099);
    tick(1);                                     // Ek+2
    check_eq("stale_ready_k2", {62'd0, din_ready_o, busy_o}, 64'd2);
    tick(1);                                     // Ek+3
    din_valid_i = 1'b0;
    check_eq("stale_accept", {62'd0, busy_o, req_o}, 64'd3);
    peer_en = 1'b1;
    wait_dones("stale_done", 6);
    wait_idle("stale_idle");
    peer_en = 1'b0;
    tick(2);

    // Reset mid-transfer
    din_i = 32'hDEAD_BEEF; din_valid_i = 1'b1;
    tick(1);
    din_valid_i = 1'b0;
    tick(2);
    check_eq("mid_pre", {31'd0, req_o, data_o}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_data", {32'd0, data_o}, 64'd0);
    check_eq("mid_rst_flags", {60'd0, req_o, busy_o, done_o, timeout_o}, 64'd0);
    tick(1);
    rst = 1'b0;
    tick(2);

    check_eq("final_dones", 64'(done_cnt), 64'd6);
    check_eq("final_timeouts", 64'(to_cnt), 64'd1);
    check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
